// File: rtl/trace_pkg.sv
// Shared definitions for the WB commit-trace streamer.
// Contents:
//   TRACE_SYNC   - first byte of every frame, lets the host resynchronise
//   TRACE_REC_W  - width of one captured record {waddr, data, pc}
//   TRACE_BYTES  - bytes per serialised record
//   trace_rec_t  - packed record layout
//   rec_state_t  - record-level FSM states
//   byte_state_t - UART byte sender FSM states
//   trace_byte() - selects frame byte idx (0..9) of a record
package trace_pkg;

    localparam logic [7:0] TRACE_SYNC  = 8'hA5;
    localparam int         TRACE_REC_W = 69;
    localparam int         TRACE_BYTES = 10;

    typedef struct packed {
        logic [4:0]  waddr;
        logic [31:0] data;
        logic [31:0] pc;
    } trace_rec_t;

    typedef enum logic {
        REC_IDLE,
        REC_SEND
    } rec_state_t;

    typedef enum logic [1:0] {
        BYTE_IDLE,
        BYTE_START,
        BYTE_DATA,
        BYTE_STOP
    } byte_state_t;

    // Frame order: sync, register, data little-endian, pc little-endian.
    function automatic logic [7:0] trace_byte(input trace_rec_t rec, input logic [3:0] idx);
        logic [7:0] b;
        case (idx)
            4'd1:    b = {3'b000, rec.waddr};
            4'd2:    b = rec.data[7:0];
            4'd3:    b = rec.data[15:8];
            4'd4:    b = rec.data[23:16];
            4'd5:    b = rec.data[31:24];
            4'd6:    b = rec.pc[7:0];
            4'd7:    b = rec.pc[15:8];
            4'd8:    b = rec.pc[23:16];
            4'd9:    b = rec.pc[31:24];
            default: b = TRACE_SYNC;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// UART 8N1 byte transmitter.
// Ports:
//   clk   - clock, rising edge
//   rst_n - synchronous active-low reset
//   start - load data and begin a byte (accepted when idle or in the last stop cycle)
//   data  - byte to send, LSB first
//   tx    - registered serial output, idle high
//   busy  - a byte is in flight
//   done  - one-cycle pulse during the last cycle of the stop bit
// A start seen together with done chains the next byte with no idle gap.
module uart_tx_byte
    import trace_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    localparam int             CW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0]  LAST_TICK = CW'(CLKS_PER_BIT - 1);

    byte_state_t   state, state_next;
    logic [CW-1:0] cnt, cnt_next;
    logic [2:0]    bit_idx, bit_next;
    logic [7:0]    shreg, shreg_next;
    logic          tx_next;
    logic          tick;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= BYTE_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            tx      <= 1'b1;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            bit_idx <= bit_next;
            shreg   <= shreg_next;
            tx      <= tx_next;
        end
    end

    assign tick = (cnt == LAST_TICK);
    assign busy = (state != BYTE_IDLE);

    // tx_next is what the line carries during the next bit period, so the
    // output flop changes exactly on bit boundaries.
    always_comb begin
        state_next = state;
        cnt_next   = cnt + 1'b1;
        bit_next   = bit_idx;
        shreg_next = shreg;
        tx_next    = tx;
        done       = 1'b0;
        case (state)
            BYTE_IDLE: begin
                cnt_next = '0;
                if (start) begin
                    state_next = BYTE_START;
                    shreg_next = data;
                    tx_next    = 1'b0;
                end
            end
            BYTE_START: begin
                if (tick) begin
                    cnt_next   = '0;
                    bit_next   = '0;
                    state_next = BYTE_DATA;
                    tx_next    = shreg[0];
                end
            end
            BYTE_DATA: begin
                if (tick) begin
                    cnt_next = '0;
                    if (bit_idx == 3'd7) begin
                        state_next = BYTE_STOP;
                        tx_next    = 1'b1;
                    end else begin
                        bit_next   = bit_idx + 3'd1;
                        shreg_next = {1'b0, shreg[7:1]};
                        tx_next    = shreg[1];
                    end
                end
            end
            BYTE_STOP: begin
                if (tick) begin
                    done     = 1'b1;
                    cnt_next = '0;
                    if (start) begin
                        state_next = BYTE_START;
                        shreg_next = data;
                        tx_next    = 1'b0;
                    end else begin
                        state_next = BYTE_IDLE;
                    end
                end
            end
            default: state_next = BYTE_IDLE;
        endcase
    end

endmodule

// File: rtl/wb_trace_uart.sv
// Commit-trace streamer: captures WB-stage register writes and sends each
// as a 10-byte UART 8N1 frame.
// Ports:
//   CLK, RST                 - clock and synchronous active-low reset
//   TRACE_EN                 - capture enable
//   HOLD                     - pipeline stalled, WB values frozen (no capture)
//   WRITE_EN_WB, WADDR_WB    - WB register write enable / destination
//   WRITE_DATA_WB, PC_WB     - WB write data and instruction PC
//   TX                       - serial output, idle high
//   BUSY                     - frame in flight or records queued
//   FIFO_LEVEL               - queued records, not counting the one being sent
//   OVERFLOW, DROP_COUNT     - sticky drop flag and saturating drop counter
module wb_trace_uart
    import trace_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic                          TRACE_EN,
    input  logic                          HOLD,
    input  logic                          WRITE_EN_WB,
    input  logic [4:0]                    WADDR_WB,
    input  logic [31:0]                   WRITE_DATA_WB,
    input  logic [31:0]                   PC_WB,
    output logic                          TX,
    output logic                          BUSY,
    output logic [$clog2(FIFO_DEPTH):0]   FIFO_LEVEL,
    output logic                          OVERFLOW,
    output logic [15:0]                   DROP_COUNT
);

    localparam int              AW         = $clog2(FIFO_DEPTH);
    localparam int              LW         = AW + 1;
    localparam logic [LW-1:0]   FULL_LEVEL = LW'(FIFO_DEPTH);
    localparam logic [3:0]      LAST_BYTE  = 4'(TRACE_BYTES - 1);

    logic [TRACE_REC_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]          wr_ptr, rd_ptr;
    logic [LW-1:0]          level;
    trace_rec_t             head, cur_rec, sel_rec, new_rec;
    rec_state_t             state, state_next;
    logic [3:0]             byte_idx, byte_idx_next, sel_idx;
    logic                   push_req, push_ok, pop, start;
    logic                   byte_done, sender_busy;
    logic [7:0]             start_data;

    assign new_rec  = '{waddr: WADDR_WB, data: WRITE_DATA_WB, pc: PC_WB};
    assign head     = trace_rec_t'(mem[rd_ptr]);
    assign push_req = TRACE_EN & WRITE_EN_WB & ~HOLD & (WADDR_WB != 5'd0);
    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    assign push_ok  = push_req & ((level != FULL_LEVEL) | pop);

    // Storage is not reset; the pointers and level define what is valid.
    always_ff @(posedge CLK) begin
        if (push_ok) mem[wr_ptr] <= new_rec;
    end

    // FIFO bookkeeping, drop accounting and the record currently on the wire.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            OVERFLOW   <= 1'b0;
            DROP_COUNT <= '0;
            cur_rec    <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr  <= rd_ptr + 1'b1;
                cur_rec <= head;
            end
            case ({push_ok, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
            if (push_req && !push_ok) begin
                OVERFLOW <= 1'b1;
                if (DROP_COUNT != 16'hFFFF) DROP_COUNT <= DROP_COUNT + 16'd1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state    <= REC_IDLE;
            byte_idx <= '0;
        end else begin
            state    <= state_next;
            byte_idx <= byte_idx_next;
        end
    end

    // The next byte is chosen combinationally so the sender chains it in the
    // same cycle its stop bit ends; a freshly popped record is read straight
    // from the FIFO head because cur_rec only updates at that edge.
    always_comb begin
        state_next    = state;
        byte_idx_next = byte_idx;
        pop           = 1'b0;
        start         = 1'b0;
        sel_rec       = cur_rec;
        sel_idx       = byte_idx;
        case (state)
            REC_IDLE: begin
                if (level != '0) begin
                    pop           = 1'b1;
                    start         = 1'b1;
                    state_next    = REC_SEND;
                    byte_idx_next = '0;
                    sel_rec       = head;
                    sel_idx       = '0;
                end
            end
            REC_SEND: begin
                if (byte_done) begin
                    if (byte_idx != LAST_BYTE) begin
                        start         = 1'b1;
                        byte_idx_next = byte_idx + 4'd1;
                        sel_idx       = byte_idx + 4'd1;
                    end else if (level != '0) begin
                        pop           = 1'b1;
                        start         = 1'b1;
                        byte_idx_next = '0;
                        sel_rec       = head;
                        sel_idx       = '0;
                    end else begin
                        state_next = REC_IDLE;
                    end
                end
            end
            default: state_next = REC_IDLE;
        endcase
    end

    assign start_data = trace_byte(sel_rec, sel_idx);

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx (
        .clk   (CLK),
        .rst_n (RST),
        .start (start),
        .data  (start_data),
        .tx    (TX),
        .busy  (sender_busy),
        .done  (byte_done)
    );

    assign FIFO_LEVEL = level;
    assign BUSY       = (state != REC_IDLE) | (level != '0) | sender_busy;

endmodule

// File: tb/tb_wb_trace_uart.sv
// Bench for wb_trace_uart with CLKS_PER_BIT=4, FIFO_DEPTH=4.
// A queue-and-timeline model predicts every output each cycle; a small UART
// receiver decodes TX so directed scenarios can also be pinned with literals.
module tb_wb_trace_uart;

    localparam int CPB       = 4;
    localparam int DEPTH     = 4;
    localparam int FRAME_CYC = 100 * CPB;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        trace_en = 1'b0;
    logic        hold = 1'b0;
    logic        we = 1'b0;
    logic [4:0]  waddr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] pc = '0;
    logic        tx, busy, overflow;
    logic [2:0]  fifo_level;
    logic [15:0] drop_count;

    int pass_count  = 0;
    int check_count = 0;

    wb_trace_uart #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .CLK           (clk),
        .RST           (rst),
        .TRACE_EN      (trace_en),
        .HOLD          (hold),
        .WRITE_EN_WB   (we),
        .WADDR_WB      (waddr),
        .WRITE_DATA_WB (wdata),
        .PC_WB         (pc),
        .TX            (tx),
        .BUSY          (busy),
        .FIFO_LEVEL    (fifo_level),
        .OVERFLOW      (overflow),
        .DROP_COUNT    (drop_count)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        check_count++;
        if (actual === expected) pass_count++;
        else $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    endtask

    // Model: pending records queue plus the frame on the wire, indexed by
    // cycles elapsed since it was popped.
    typedef struct {
        logic [4:0]  w;
        logic [31:0] d;
        logic [31:0] p;
    } rec_t;

    rec_t       m_q[$];
    logic [7:0] m_bytes [10];
    bit         m_active = 0;
    int         m_pos = 0;
    bit         m_ovf = 0;
    int         m_drops = 0;
    bit         m_valid = 0;

    always @(posedge clk) begin
        rec_t r;
        if (!rst) begin
            m_q.delete();
            m_active = 0;
            m_pos = 0;
            m_ovf = 0;
            m_drops = 0;
            m_valid = 1;
        end else begin
            if (m_active) begin
                if (m_pos == FRAME_CYC - 1) m_active = 0;
                else m_pos++;
            end
            if (!m_active && m_q.size() > 0) begin
                r = m_q.pop_front();
                m_bytes = '{8'hA5, {3'b0, r.w}, r.d[7:0], r.d[15:8], r.d[23:16], r.d[31:24],
                            r.p[7:0], r.p[15:8], r.p[23:16], r.p[31:24]};
                m_active = 1;
                m_pos = 0;
            end
            if (trace_en && we && !hold && waddr != 5'd0) begin
                if (m_q.size() < DEPTH) begin
                    r.w = waddr; r.d = wdata; r.p = pc;
                    m_q.push_back(r);
                end else begin
                    m_ovf = 1;
                    if (m_drops != 16'hFFFF) m_drops++;
                end
            end
        end
    end

    function automatic logic model_tx();
        int bit_i;
        if (!m_active) return 1'b1;
        bit_i = (m_pos / CPB) % 10;
        if (bit_i == 0) return 1'b0;
        if (bit_i == 9) return 1'b1;
        return m_bytes[m_pos / (10 * CPB)][bit_i - 1];
    endfunction

    always @(negedge clk) begin
        if (m_valid) begin
            checkOutput("tx", 32'(tx), 32'(model_tx()));
            checkOutput("busy", 32'(busy), 32'(m_active || m_q.size() > 0));
            checkOutput("fifo_level", 32'(fifo_level), 32'(m_q.size()));
            checkOutput("overflow", 32'(overflow), 32'(m_ovf));
            checkOutput("drop_count", 32'(drop_count), 32'(m_drops));
        end
    end

    // Independent decoder: start detected at a low sample, bits sampled mid-period.
    logic [7:0] rx_bytes[$];
    bit         rx_active = 0;
    int         rx_cnt = 0;
    logic [7:0] rx_shift;
    int         tx_low_count = 0;

    always @(negedge clk) begin
        if (tx === 1'b0) tx_low_count++;
        if (!rst) begin
            rx_active = 0;
        end else if (!rx_active) begin
            if (tx === 1'b0) begin
                rx_active = 1;
                rx_cnt = 0;
            end
        end else begin
            rx_cnt++;
            if (rx_cnt == 9 * CPB + CPB / 2) begin
                rx_bytes.push_back(rx_shift);
                rx_active = 0;
            end else if (rx_cnt % CPB == CPB / 2 && rx_cnt / CPB >= 1 && rx_cnt / CPB <= 8) begin
                rx_shift[rx_cnt / CPB - 1] = tx;
            end
        end
    end

    // Drives one cycle of inputs, held across the next rising edge.
    task automatic applyStimulus(input logic en, input logic hd, input logic wen,
                                 input logic [4:0] a, input logic [31:0] d, input logic [31:0] p);
        trace_en = en; hold = hd; we = wen; waddr = a; wdata = d; pc = p;
        @(negedge clk);
    endtask

    task automatic idleCycles(input int n);
        we = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish, %0d/%0d", pass_count, check_count);
        $fatal(1, "[TB] timeout");
    end

    initial begin
        logic [7:0] exp1 [10];
        logic [4:0] exp3 [6];
        int low_before;

        @(negedge clk);
        rst = 1'b0;
        idleCycles(2);
        checkOutput("reset_tx", 32'(tx), 32'd1);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_level", 32'(fifo_level), 32'd0);
        checkOutput("reset_overflow", 32'(overflow), 32'd0);
        checkOutput("reset_drops", 32'(drop_count), 32'd0);
        rst = 1'b1;
        idleCycles(2);

        // Single commit: latency and byte content.
        rx_bytes.delete();
        applyStimulus(1, 0, 1, 5'd5, 32'h12345678, 32'h10);
        checkOutput("t1_tx_after_capture", 32'(tx), 32'd1);
        checkOutput("t1_level_after_capture", 32'(fifo_level), 32'd1);
        idleCycles(1);
        checkOutput("t1_tx_after_pop", 32'(tx), 32'd0);
        checkOutput("t1_level_after_pop", 32'(fifo_level), 32'd0);
        idleCycles(399);
        checkOutput("t1_busy_last_cycle", 32'(busy), 32'd1);
        idleCycles(1);
        checkOutput("t1_busy_done", 32'(busy), 32'd0);
        idleCycles(5);
        exp1 = '{8'hA5, 8'h05, 8'h78, 8'h56, 8'h34, 8'h12, 8'h10, 8'h00, 8'h00, 8'h00};
        checkOutput("t1_byte_count", 32'(rx_bytes.size()), 32'd10);
        for (int i = 0; i < 10 && i < rx_bytes.size(); i++)
            checkOutput($sformatf("t1_byte%0d", i), 32'(rx_bytes[i]), 32'(exp1[i]));

        // HOLD suppresses duplicates; x0 never traced.
        rx_bytes.delete();
        applyStimulus(1, 1, 1, 5'd7, 32'hAAAA5555, 32'h20);
        applyStimulus(1, 1, 1, 5'd7, 32'hAAAA5555, 32'h20);
        checkOutput("t2_level_while_hold", 32'(fifo_level), 32'd0);
        applyStimulus(1, 0, 1, 5'd7, 32'hAAAA5555, 32'h20);
        checkOutput("t2_level_after_release", 32'(fifo_level), 32'd1);
        applyStimulus(1, 0, 1, 5'd0, 32'hDEADBEEF, 32'h24);
        checkOutput("t2_level_after_x0", 32'(fifo_level), 32'd0);
        idleCycles(420);
        checkOutput("t2_byte_count", 32'(rx_bytes.size()), 32'd10);
        if (rx_bytes.size() >= 3) begin
            checkOutput("t2_waddr", 32'(rx_bytes[1]), 32'h07);
            checkOutput("t2_data0", 32'(rx_bytes[2]), 32'h55);
        end

        // Overflow, then a push coinciding with a frame-end pop.
        rx_bytes.delete();
        for (int i = 1; i <= 7; i++)
            applyStimulus(1, 0, 1, 5'(i), 32'h11111111 * i, 32'h100 + 4 * i);
        checkOutput("t3_drops", 32'(drop_count), 32'd2);
        checkOutput("t3_overflow", 32'(overflow), 32'd1);
        checkOutput("t3_level_full", 32'(fifo_level), 32'd4);
        idleCycles(394);
        checkOutput("t4_level_before", 32'(fifo_level), 32'd4);
        applyStimulus(1, 0, 1, 5'd8, 32'hCAFEF00D, 32'h200);
        checkOutput("t4_level_after", 32'(fifo_level), 32'd4);
        checkOutput("t4_drops_unchanged", 32'(drop_count), 32'd2);
        idleCycles(2010);
        checkOutput("t3_busy_drained", 32'(busy), 32'd0);
        checkOutput("t3_byte_count", 32'(rx_bytes.size()), 32'd60);
        exp3 = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd8};
        for (int f = 0; f < 6 && 10 * f + 1 < rx_bytes.size(); f++)
            checkOutput($sformatf("t3_frame%0d_waddr", f), 32'(rx_bytes[10 * f + 1]), 32'(exp3[f]));

        // Reset mid-byte with records queued.
        applyStimulus(1, 0, 1, 5'd9, 32'h01020304, 32'h300);
        applyStimulus(1, 0, 1, 5'd10, 32'h05060708, 32'h304);
        applyStimulus(1, 0, 1, 5'd11, 32'h090A0B0C, 32'h308);
        idleCycles(175);
        checkOutput("t5_level_before", 32'(fifo_level), 32'd2);
        rst = 1'b0;
        idleCycles(1);
        rst = 1'b1;
        checkOutput("t5_tx", 32'(tx), 32'd1);
        checkOutput("t5_level", 32'(fifo_level), 32'd0);
        checkOutput("t5_busy", 32'(busy), 32'd0);
        checkOutput("t5_drops", 32'(drop_count), 32'd0);
        checkOutput("t5_overflow", 32'(overflow), 32'd0);
        low_before = tx_low_count;
        idleCycles(500);
        checkOutput("t5_no_activity", 32'(tx_low_count - low_before), 32'd0);

        // TRACE_EN gates capture only.
        rx_bytes.delete();
        for (int i = 1; i <= 5; i++)
            applyStimulus(0, 0, 1, 5'(i + 12), 32'h0, 32'h400);
        checkOutput("t6_disabled_tx", 32'(tx), 32'd1);
        checkOutput("t6_disabled_busy", 32'(busy), 32'd0);
        applyStimulus(1, 0, 1, 5'd20, 32'h89ABCDEF, 32'h500);
        idleCycles(100);
        for (int i = 0; i < 3; i++)
            applyStimulus(0, 0, 1, 5'd21, 32'h1, 32'h504);
        idleCycles(320);
        checkOutput("t6_busy_end", 32'(busy), 32'd0);
        checkOutput("t6_byte_count", 32'(rx_bytes.size()), 32'd10);
        if (rx_bytes.size() >= 10) begin
            checkOutput("t6_waddr", 32'(rx_bytes[1]), 32'h14);
            checkOutput("t6_data3", 32'(rx_bytes[5]), 32'h89);
            checkOutput("t6_pc1", 32'(rx_bytes[7]), 32'h05);
        end

        $display("[TB] %0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
